add_chain_arbiter: RTL and testbench
====================================

# add_chain_arbiter

Shares one registered increment datapath among NUM_REQ requesters. Each accepted request carries an operand and a step count; the block applies the same "add one" operation that the add_one/add_two submodules perform once per step, sequentially, on a single accumulator. It returns the result with the requester's ID. It sits between several caller modules and the shared increment resource. It replaces per-caller nested submodule calls with one time-multiplexed, round-robin-arbitrated unit.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits
- NUM_REQ, 4, number of requesters (power of two, ≥2)
- STEP_W, 3, step-count width; steps range 0..2^STEP_W-1
- ID_W, 2, clog2(NUM_REQ)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*WIDTH  operand; requester i at [i*WIDTH +: WIDTH]
- req_steps  in  NUM_REQ*STEP_W  step count; requester i at [i*STEP_W +: STEP_W]
- req_ready  out  NUM_REQ  one-hot accept; at most one bit set
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  WIDTH  result = operand + steps, mod 2^WIDTH
- resp_id  out  ID_W  index of requester that owns resp_data
- busy  out  1  high in RUN or DONE

## Operation
- Registered state: state (IDLE/RUN/DONE), acc[WIDTH], remaining[STEP_W], cur_id[ID_W], last_grant[ID_W].
- Reset values: state=IDLE, acc=0, remaining=0, cur_id=0, last_grant=NUM_REQ-1. Outputs: resp_valid=0, resp_data=0, resp_id=0, busy=0, req_ready=0.
- req_ready is combinational. While reset is asserted it is forced to 0.
- IDLE:
  - Round-robin search over req_valid starting at last_grant+1 (mod NUM_REQ). The first valid requester i gets req_ready[i]=1.
  - If no requester is valid, req_ready=0.
  - On accept: acc←req_data[i], cur_id←i, last_grant←i.
  - If steps==0, go to DONE. Otherwise remaining←steps and go to RUN.
- RUN:
  - Each cycle: acc←acc+1 (truncated to WIDTH; 0xFF+1=0x00) and remaining←remaining−1.
  - If remaining==1 this cycle, go to DONE.
  - req_ready=0.
- DONE:
  - resp_valid=1, resp_data=acc, resp_id=cur_id.
  - If resp_ready=1, go to IDLE. Otherwise hold; acc and cur_id must not change.
  - req_ready=0. No accept happens in the same cycle as the response handoff.
- resp_valid = (state==DONE). busy = (state!=IDLE). resp_data and resp_id are driven from registers.
- Requesters must hold valid, data and steps stable until their ready bit is seen. The block re-arbitrates every IDLE cycle, so a dropped valid is tolerated and no grant is issued for it.
- Requesters that are not granted are not stalled beyond waiting. No ID is skipped in rotation.

## Timing
- Accept in cycle T (state IDLE, req_valid[i]&req_ready[i]):
  - RUN occupies cycles T+1..T+steps.
  - resp_valid first rises in cycle T+steps+1.
  - steps==0 gives resp_valid at T+1.
- Back-to-back throughput: at most one request per steps+2 cycles (IDLE accept, steps×RUN, DONE handoff). Each cycle resp_ready is low adds one cycle.
- Round-robin fairness: with all requesters continuously valid, grants rotate strictly in order 0,1,…,NUM_REQ−1,0.
- Reset asserted in any state:
  - All registers take their reset values immediately, without waiting for a clock edge.
  - Any in-flight result is discarded and no response is produced.
  - The first grant after release goes to the lowest-index valid requester.
- resp_ready while state≠DONE is ignored.

## Test plan
- Single request: req_valid=0001, req_data[0]=0x10, steps=3, resp_ready=1 → req_ready=0001 at T; resp_valid first high at T+4 with resp_data=0x13, resp_id=0; busy high T+1..T+4.
- Wrap-around: requester 2 sends data=0xFE, steps=5 → resp_data=0x03, resp_id=2, resp_valid at T+6.
- Zero steps: requester 1 sends data=0x5A, steps=0 → resp_valid at T+1 with resp_data=0x5A, resp_id=1; no RUN cycle.
- Fairness: all four requesters continuously valid, steps=1, resp_ready=1 → accepts every 3 cycles, grant order 0,1,2,3,0,1; req_ready is never multi-hot.
- Backpressure: resp_ready=0 for 3 cycles in DONE → resp_valid, resp_data and resp_id stay stable and req_ready=0 throughout; after resp_ready=1, IDLE follows and the next grant occurs one cycle after the handoff.
- Reset mid-RUN: requester 3 sends steps=6, reset is pulsed at T+2 → resp_valid=0, busy=0 and req_ready=0 during reset; no response for requester 3; after release with req_valid=1001, the grant goes to requester 0.

Source files
------------

// File: rtl/add_chain_arbiter.sv
// Time-multiplexed increment unit shared by NUM_REQ requesters under round-robin arbitration.
// Each accepted operand is incremented once per cycle for its step count, then returned with its ID.
module add_chain_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int STEP_W  = 3,
    parameter int ID_W    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*STEP_W-1:0] req_steps,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WIDTH-1:0]          resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  acc, acc_nxt;
    logic [STEP_W-1:0] remaining, remaining_nxt;
    logic [ID_W-1:0]   cur_id, cur_id_nxt;
    logic [ID_W-1:0]   last_grant, last_grant_nxt;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  grant_data;
    logic [STEP_W-1:0] grant_steps;

    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] a);
        return a + WIDTH'(1);
    endfunction

    // Search starts just after the last grant; ID_W-bit addition wraps modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = last_grant + ID_W'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign grant_data  = req_data[grant_id*WIDTH +: WIDTH];
    assign grant_steps = req_steps[grant_id*STEP_W +: STEP_W];

    always_comb begin
        req_ready = '0;
        if (!reset && state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        remaining_nxt  = remaining;
        cur_id_nxt     = cur_id;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    acc_nxt        = grant_data;
                    cur_id_nxt     = grant_id;
                    last_grant_nxt = grant_id;
                    if (grant_steps == '0) begin
                        state_nxt = DONE;
                    end else begin
                        remaining_nxt = grant_steps;
                        state_nxt     = RUN;
                    end
                end
            end
            RUN: begin
                acc_nxt       = inc_wrap(acc);
                remaining_nxt = remaining - STEP_W'(1);
                if (remaining == STEP_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register boundary
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            remaining  <= '0;
            cur_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            remaining  <= remaining_nxt;
            cur_id     <= cur_id_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign resp_data  = acc;
    assign resp_id    = cur_id;

endmodule

// File: tb/tb_add_chain_arbiter.sv
// Directed bench for add_chain_arbiter: vector table of single requests plus
// fairness, backpressure and reset-mid-run sequences.
module tb_add_chain_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int STEP_W  = 3;
    localparam int ID_W    = 2;

    logic                      clock;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*WIDTH-1:0]  req_data;
    logic [NUM_REQ*STEP_W-1:0] req_steps;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [WIDTH-1:0]          resp_data;
    logic [ID_W-1:0]           resp_id;
    logic                      busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [2:0] steps;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    add_chain_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .STEP_W(STEP_W), .ID_W(ID_W)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_steps(req_steps),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] d, input logic [2:0] s);
        req_data[id*WIDTH +: WIDTH]    = d;
        req_steps[id*STEP_W +: STEP_W] = s;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    // Single request from one requester; latency counted in clock edges after accept.
    task automatic run_vec(input int id, input logic [7:0] d, input logic [2:0] s, input logic [7:0] e);
        int lat;
        set_req(id, d, s);
        resp_ready = 1'b1;
        req_valid  = 4'(1 << id);
        #1;
        chk("vec_ready", 32'(req_ready), 32'(1 << id));
        chk("vec_idle_busy", 32'(busy), 0);
        tick();
        req_valid = '0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            chk("vec_run_busy", 32'(busy), 1);
            chk("vec_run_ready", 32'(req_ready), 0);
            tick();
            lat++;
        end
        chk("vec_latency", 32'(lat), 32'(int'(s) + 1));
        chk("vec_data", 32'(resp_data), 32'(e));
        chk("vec_id", 32'(resp_id), 32'(id));
        chk("vec_done_busy", 32'(busy), 1);
        tick();
        chk("vec_after_valid", 32'(resp_valid), 0);
        chk("vec_after_busy", 32'(busy), 0);
    endtask

    initial begin
        int cyc;
        int prev;
        int w;

        vecs[0] = '{id: 0, data: 8'h10, steps: 3'd3, exp: 8'h13};
        vecs[1] = '{id: 2, data: 8'hFE, steps: 3'd5, exp: 8'h03};
        vecs[2] = '{id: 1, data: 8'h5A, steps: 3'd0, exp: 8'h5A};
        vecs[3] = '{id: 3, data: 8'hFF, steps: 3'd1, exp: 8'h00};
        vecs[4] = '{id: 0, data: 8'hF9, steps: 3'd7, exp: 8'h00};
        vecs[5] = '{id: 2, data: 8'h80, steps: 3'd2, exp: 8'h82};

        // Reset state with every requester asserting valid
        reset      = 1'b1;
        req_valid  = '1;
        req_data   = 32'hA1B2C3D4;
        req_steps  = '1;
        resp_ready = 1'b0;
        #3;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_data", 32'(resp_data), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_busy", 32'(busy), 0);
        tick();
        tick();
        chk("rst_hold_ready", 32'(req_ready), 0);
        chk("rst_hold_busy", 32'(busy), 0);
        req_valid = '0;
        reset     = 1'b0;
        #1;
        chk("idle_no_valid_ready", 32'(req_ready), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i].id, vecs[i].data, vecs[i].steps, vecs[i].exp);
        end

        // Fairness: all valid, steps=1, grants every 3 cycles in order 0,1,2,3,0,1
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i * 16), 3'd1);
        resp_ready = 1'b1;
        req_valid  = '1;
        #1;
        cyc  = 0;
        prev = 0;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (req_ready == '0 && w < 10) begin
                tick();
                cyc++;
                w++;
            end
            chk("fair_onehot", 32'($onehot0(req_ready)), 1);
            chk("fair_grant", 32'(req_ready), 32'(1 << (g % NUM_REQ)));
            if (g > 0) chk("fair_spacing", 32'(cyc - prev), 3);
            prev = cyc;
            tick();
            cyc++;
        end
        req_valid = '0;
        tick();
        tick();
        tick();

        // Backpressure: requester 1 held in DONE while requester 2 waits
        pulse_reset();
        set_req(1, 8'h20, 3'd2);
        set_req(2, 8'h77, 3'd0);
        resp_ready = 1'b0;
        req_valid  = 4'b0110;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100;
        w = 0;
        while (!resp_valid && w < 10) begin
            tick();
            w++;
        end
        chk("bp_latency", 32'(w), 2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(resp_valid), 1);
            chk("bp_data", 32'(resp_data), 32'h22);
            chk("bp_id", 32'(resp_id), 1);
            chk("bp_ready", 32'(req_ready), 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_handoff_valid", 32'(resp_valid), 1);
        chk("bp_handoff_ready", 32'(req_ready), 0);
        tick();
        chk("bp_idle_valid", 32'(resp_valid), 0);
        chk("bp_next_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("bp_next_valid", 32'(resp_valid), 1);
        chk("bp_next_data", 32'(resp_data), 32'h77);
        chk("bp_next_id", 32'(resp_id), 2);
        tick();

        // Reset pulsed two cycles into a 6-step run for requester 3
        set_req(3, 8'h40, 3'd6);
        set_req(0, 8'h33, 3'd0);
        resp_ready = 1'b1;
        req_valid  = 4'b1000;
        #1;
        chk("rr_grant3", 32'(req_ready), 32'h8);
        tick();
        tick();
        chk("rr_busy_before", 32'(busy), 1);
        reset     = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("rr_async_valid", 32'(resp_valid), 0);
        chk("rr_async_busy", 32'(busy), 0);
        chk("rr_async_ready", 32'(req_ready), 0);
        tick();
        chk("rr_hold_valid", 32'(resp_valid), 0);
        chk("rr_hold_ready", 32'(req_ready), 0);
        reset = 1'b0;
        #1;
        chk("rr_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("rr_resp_valid", 32'(resp_valid), 1);
        chk("rr_resp_id", 32'(resp_id), 0);
        chk("rr_resp_data", 32'(resp_data), 32'h33);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("rr_no_stale", 32'(resp_valid), 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
